// File: rtl/if_inst_queue.sv
// IF->ID instruction queue: circular buffer of {adef, inst, pc} entries, flushed on exception/ertn or branch cancel.
// Optional zero-latency empty-queue forwarding when IFQ_BYPASS_EN is defined.
module if_inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       br_cancel,
    input  logic                       fs_to_ds_valid,
    input  logic [WIDTH-1:0]           fs_to_ds_bus,
    output logic                       iq_allow_in,
    output logic                       iq_to_ds_valid,
    output logic [WIDTH-1:0]           iq_to_ds_bus,
    input  logic                       ds_allow_in,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;

    logic             w_empty;
    logic             w_full;
    logic             w_kill;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_kill  = flush | br_cancel;
    assign w_head  = w_empty ? WIDTH'(0) : r_mem[r_rptr[AW-1:0]];

    assign iq_allow_in = !w_full;
    assign iq_count    = r_wptr - r_rptr;

`ifdef IFQ_BYPASS_EN
    logic w_bypass;

    // Empty queue and a ready consumer: hand the IF entry straight to ID without storing it.
    assign w_bypass       = w_empty & fs_to_ds_valid & ds_allow_in & !w_kill;
    assign w_push         = fs_to_ds_valid & iq_allow_in & !w_kill & !w_bypass;
    assign w_pop          = !w_empty & !w_kill & ds_allow_in;
    assign iq_to_ds_valid = (!w_empty & !w_kill) | w_bypass;
    assign iq_to_ds_bus   = w_bypass ? fs_to_ds_bus : w_head;
`else
    assign w_push         = fs_to_ds_valid & iq_allow_in & !w_kill;
    assign iq_to_ds_valid = !w_empty & !w_kill;
    assign w_pop          = iq_to_ds_valid & ds_allow_in;
    assign iq_to_ds_bus   = w_head;
`endif

    // Pointer update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset || w_kill) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Entry storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wptr[AW-1:0]] <= fs_to_ds_bus;
    end

endmodule
